shift_register_universal: RTL and testbench

Parametrised universal shift register, the successor to the team's single-direction left shifter. It adds left and right logical shifts, left and right rotates, and arithmetic right shift, applied in lanes of STEP bits per cycle. It also adds an autonomous burst mode that performs a programmed number of shifts with busy/done status. It sits in datapath and serialiser front-ends where a CPU-side controller either single-steps the register or hands off an N-shift job.

---
 rtl/shift_register_universal_pkg.sv | 19 +
 rtl/shift_register_universal_if.sv | 28 ++
 rtl/shift_register_universal_shift_step_mux.sv | 38 +++
 rtl/shift_register_universal.sv | 100 ++++++++++
 tb/tb_shift_register_universal.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_register_universal_pkg.sv
// Shared encodings for the universal shift register: operation modes and burst FSM states.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SLL  = 3'b001,
        MODE_SRL  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_SRA  = 3'b101
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_register_universal_if.sv
// Control/data bundle of the universal shift register; the controller drives the master side.
interface shift_register_universal_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
);
    logic               load;
    logic [WIDTH-1:0]   parallel_in;
    logic               en;
    logic [2:0]         mode;
    logic [STEP-1:0]    serial_in;
    logic               start;
    logic [CNT_W-1:0]   shift_count;
    logic [STEP-1:0]    serial_out;
    logic [WIDTH-1:0]   parallel_out;
    logic               busy;
    logic               done;

    modport master (
        output load, parallel_in, en, mode, serial_in, start, shift_count,
        input  serial_out, parallel_out, busy, done
    );

    modport slave (
        input  load, parallel_in, en, mode, serial_in, start, shift_count,
        output serial_out, parallel_out, busy, done
    );
endinterface

// File: rtl/shift_register_universal_shift_step_mux.sv
// One shift/rotate step of STEP bits plus the lane that falls off for the given mode.
module shift_step_mux
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [2:0]       mode_i,
    input  logic [STEP-1:0]  serial_i,
    output logic [WIDTH-1:0] next_o,
    output logic [STEP-1:0]  serial_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_o   = cur_i;
        serial_o = cur_i[WIDTH-1 -: STEP];
        case (mode_i)
            MODE_SLL: next_o = {cur_i[WIDTH-STEP-1:0], serial_i};
            MODE_SRL: begin
                next_o   = {serial_i, cur_i[WIDTH-1:STEP]};
                serial_o = cur_i[STEP-1:0];
            end
            MODE_ROL: next_o = {cur_i[WIDTH-STEP-1:0], cur_i[WIDTH-1 -: STEP]};
            MODE_ROR: begin
                next_o   = {cur_i[STEP-1:0], cur_i[WIDTH-1:STEP]};
                serial_o = cur_i[STEP-1:0];
            end
            MODE_SRA: begin
                next_o   = {{STEP{cur_i[WIDTH-1]}}, cur_i[WIDTH-1:STEP]};
                serial_o = cur_i[STEP-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, single-step shifting and an autonomous N-shift burst.
module shift_register_universal
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    shift_register_universal_if.slave  bus
);

    if ((STEP < 1) || (STEP >= WIDTH) || ((WIDTH % STEP) != 0)) begin : g_bad_params
        $error("shift_register_universal: WIDTH must be a multiple of STEP and STEP < WIDTH");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bmode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       eff_mode;
    logic [STEP-1:0]  serial_out;

    // A running burst owns the datapath; otherwise the live mode drives both shift and serial_out.
    assign eff_mode = (state_q == ST_RUN) ? bmode_q : bus.mode;

    shift_step_mux #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .cur_i    (data_q),
        .mode_i   (eff_mode),
        .serial_i (bus.serial_in),
        .next_o   (data_d),
        .serial_o (serial_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bmode_q <= MODE_HOLD;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            data_q  <= bus.parallel_in;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        bmode_q <= bus.mode;
                        cnt_q   <= bus.shift_count;
                        if (bus.shift_count != '0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (bus.en) begin
                        data_q <= data_d;
                    end
                end
                ST_RUN: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.parallel_out = data_q;
    assign bus.serial_out   = serial_out;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for the universal shift register: STEP=1 and STEP=2 instances against an arithmetic model.
module tb_shift_register_universal;
    import shift_reg_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_register_universal_if #(.WIDTH(8), .STEP(1), .CNT_W(4)) if1 ();
    shift_register_universal_if #(.WIDTH(8), .STEP(2), .CNT_W(4)) if2 ();

    shift_register_universal #(.WIDTH(8), .STEP(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );
    shift_register_universal #(.WIDTH(8), .STEP(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus currently on the pins (shared by both instances).
    logic       s_load, s_en, s_start;
    logic [7:0] s_pin;
    logic [2:0] s_mode;
    logic [1:0] s_sin;
    logic [3:0] s_cnt;

    // Behavioural model state, index 0 = STEP 1, index 1 = STEP 2.
    logic [7:0] m_reg   [2];
    bit         m_run   [2];
    bit         m_done  [2];
    int         m_left  [2];
    logic [2:0] m_bmode [2];

    function automatic logic [7:0] ref_op(input logic [7:0] r, input logic [2:0] m,
                                          input logic [1:0] sin, input int s);
        int v    = int'(r);
        int mask = (1 << s) - 1;
        int f    = int'(sin) & mask;
        int res;
        case (m)
            3'd1:    res = (v << s) | f;
            3'd2:    res = (v >> s) | (f << (8 - s));
            3'd3:    res = (v << s) | (v >> (8 - s));
            3'd4:    res = (v >> s) | (v << (8 - s));
            3'd5:    res = int'($signed(r)) >>> s;
            default: res = v;
        endcase
        return res[7:0];
    endfunction

    function automatic logic [7:0] ref_ser(input logic [7:0] r, input logic [2:0] m, input int s);
        int v = int'(r);
        int res;
        if (m == 3'd2 || m == 3'd4 || m == 3'd5) res = v & ((1 << s) - 1);
        else                                     res = v >> (8 - s);
        return res[7:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_reg[k] = 8'h00; m_run[k] = 0; m_done[k] = 0; m_left[k] = 0; m_bmode[k] = 3'd0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (s_load) begin
                m_reg[k] = s_pin; m_run[k] = 0; m_done[k] = 0;
            end else if (m_run[k]) begin
                m_reg[k]  = ref_op(m_reg[k], m_bmode[k], s_sin, k + 1);
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_run[k] = 0; m_done[k] = 1;
                end
            end else if (m_done[k]) begin
                m_done[k] = 0;
            end else if (s_start) begin
                if (s_cnt > 0) begin
                    m_run[k] = 1; m_left[k] = int'(s_cnt); m_bmode[k] = s_mode;
                end else begin
                    m_done[k] = 1;
                end
            end else if (s_en) begin
                m_reg[k] = ref_op(m_reg[k], s_mode, s_sin, k + 1);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] po, so;
        logic       bz, dn;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                po = if1.parallel_out; so = {7'd0, if1.serial_out}; bz = if1.busy; dn = if1.done;
            end else begin
                po = if2.parallel_out; so = {6'd0, if2.serial_out}; bz = if2.busy; dn = if2.done;
            end
            check($sformatf("step%0d parallel_out", k + 1), po, m_reg[k]);
            check($sformatf("step%0d serial_out", k + 1), so,
                  ref_ser(m_reg[k], m_run[k] ? m_bmode[k] : s_mode, k + 1));
            check($sformatf("step%0d busy", k + 1), {7'd0, bz}, {7'd0, m_run[k]});
            check($sformatf("step%0d done", k + 1), {7'd0, dn}, {7'd0, m_done[k]});
        end
    endtask

    task automatic apply(input logic l, input logic [7:0] p, input logic e, input logic [2:0] m,
                         input logic [1:0] s, input logic st, input logic [3:0] c);
        s_load = l; s_pin = p; s_en = e; s_mode = m; s_sin = s; s_start = st; s_cnt = c;
        if1.load = l; if1.parallel_in = p; if1.en = e; if1.mode = m;
        if1.serial_in = s[0]; if1.start = st; if1.shift_count = c;
        if2.load = l; if2.parallel_in = p; if2.en = e; if2.mode = m;
        if2.serial_in = s; if2.start = st; if2.shift_count = c;
    endtask

    task automatic idle();
        apply(1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        check_all();
        #2 rst_n = 1'b1;

        // Single steps from the reference cases.
        apply(1'b1, 8'hA5, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_SLL, 2'b01, 1'b0, 4'd0);
        #1 check("sll serial_out before shift", {7'd0, if1.serial_out}, 8'h01);
        tick();
        check("sll 0xA5 result", if1.parallel_out, 8'h4B);
        apply(1'b1, 8'h85, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_SRA, 2'b00, 1'b0, 4'd0); tick();
        check("sra 0x85 result", if1.parallel_out, 8'hC2);
        apply(1'b1, 8'h81, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_ROR, 2'b00, 1'b0, 4'd0); tick();
        check("ror 0x81 result", if1.parallel_out, 8'hC0);
        apply(1'b1, 8'h81, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_SRL, 2'b00, 1'b0, 4'd0); tick();
        check("srl 0x81 result", if1.parallel_out, 8'h40);

        // ROL burst of 3, with a stray start during RUN.
        apply(1'b1, 8'h96, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_ROL, 2'b00, 1'b1, 4'd3); tick();
        check("burst E0 busy", {7'd0, if1.busy}, 8'h01);
        apply(1'b0, 8'h00, 1'b0, MODE_SRL, 2'b00, 1'b0, 4'd0); tick();
        check("burst E1 data", if1.parallel_out, 8'h2D);
        apply(1'b0, 8'h00, 1'b1, MODE_SRA, 2'b00, 1'b1, 4'd5); tick();
        check("burst E2 data", if1.parallel_out, 8'h5A);
        idle(); tick();
        check("burst E3 data", if1.parallel_out, 8'hB4);
        check("burst done pulse", {7'd0, if1.done}, 8'h01);
        tick();
        check("burst done cleared", {7'd0, if1.done}, 8'h00);

        // Two-bit lane and zero-count burst.
        apply(1'b1, 8'hF0, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_SLL, 2'b01, 1'b0, 4'd0);
        #1 check("step2 serial_out before shift", {6'd0, if2.serial_out}, 8'h03);
        tick();
        check("step2 sll 0xF0 result", if2.parallel_out, 8'hC1);
        apply(1'b0, 8'h00, 1'b1, MODE_ROL, 2'b00, 1'b1, 4'd0); tick();
        check("zero-count done", {7'd0, if2.done}, 8'h01);
        check("zero-count data", if2.parallel_out, 8'hC1);
        idle(); tick();

        // Load aborts a 5-shift burst at its second edge.
        apply(1'b0, 8'h00, 1'b0, MODE_ROR, 2'b00, 1'b1, 4'd5); tick();
        idle(); tick();
        apply(1'b1, 8'h3C, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        check("abort load data", if1.parallel_out, 8'h3C);
        check("abort busy", {7'd0, if1.busy}, 8'h00);
        idle(); tick(); tick();

        // Asynchronous reset in the middle of a burst.
        apply(1'b0, 8'h00, 1'b0, MODE_SLL, 2'b11, 1'b1, 4'd6); tick();
        idle(); tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        #1 rst_n = 1'b1;
        apply(1'b1, 8'h5A, 1'b0, 3'd0, 2'd0, 1'b0, 4'd0); tick();
        apply(1'b0, 8'h00, 1'b1, MODE_ROL, 2'b00, 1'b0, 4'd0); tick();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 15) == 0, 8'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 2'($urandom), $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 6)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
